// File: rtl/event_encoder.sv
// Purpose : capture rising edges on 8 request lines and emit one 3-bit index per event.
// Latency : req rises in cycle N -> valid=1 with its code in cycle N+2; one IDLE bubble after each accept.
// Backpr. : code/valid are held while ready=0; new edges keep accumulating in pending, and an edge on an already-pending bit sets ovf.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   req      8 level request lines; a 0->1 transition creates an event
//   code     index of the offered event (meaningful while valid=1)
//   valid    an event is being offered
//   ready    consumer accepts; handshake on valid & ready
//   pending  registered pending-event mask
//   ovf      sticky lost-event flag, cleared only by rst
module event_encoder #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] code,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] pending,
    output logic       ovf
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] req_q;
    logic [7:0] req_edge;
    logic [7:0] ack_mask;
    logic       hs;
    logic [2:0] ptr;
    logic [2:0] ptr_nxt;
    logic [2:0] code_nxt;
    logic [2:0] base;
    logic [2:0] sel_idx;

    assign valid    = (state == OFFER);
    assign hs       = valid & ready;
    assign req_edge = req & ~req_q;
    assign ack_mask = hs ? (8'b1 << code) : 8'b0;
    assign base     = ROUND_ROBIN ? ptr : 3'd0;

    // First set bit of pending scanning upward from base, wrapping 7->0.
    // Only consulted in IDLE when pending is non-zero, so the all-zero
    // default never gets loaded into code.
    always_comb begin
        sel_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[base + 3'(i)]) begin
                sel_idx = base + 3'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (|pending) begin
                    code_nxt  = sel_idx;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (ready) begin
                    state_nxt = IDLE;
                    if (ROUND_ROBIN) begin
                        ptr_nxt = code + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // req_q follows req even during reset so lines already high at
        // release are treated as old levels, not new events.
        req_q <= req;
        if (rst) begin
            state   <= IDLE;
            code    <= 3'd0;
            ptr     <= 3'd0;
            pending <= 8'h00;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            code    <= code_nxt;
            ptr     <= ptr_nxt;
            // An edge on a bit being acknowledged this cycle is a fresh
            // event, not a lost one, so the ack is masked out of ovf.
            pending <= (pending & ~ack_mask) | req_edge;
            if (|(req_edge & pending & ~ack_mask)) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_event_encoder.sv
module tb_event_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_fp, req_rr;
    logic       ready_fp, ready_rr;
    logic [2:0] code_fp, code_rr;
    logic       valid_fp, valid_rr;
    logic [7:0] pending_fp, pending_rr;
    logic       ovf_fp, ovf_rr;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_fp_q[$];
    logic [2:0] exp_rr_q[$];

    always #5 clk = ~clk;

    event_encoder #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .req(req_fp), .code(code_fp), .valid(valid_fp),
        .ready(ready_fp), .pending(pending_fp), .ovf(ovf_fp)
    );

    event_encoder #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .req(req_rr), .code(code_rr), .valid(valid_rr),
        .ready(ready_rr), .pending(pending_rr), .ovf(ovf_rr)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: every handshake pops the code the stimulus predicted.
    always @(negedge clk) begin
        if (!rst && valid_fp && ready_fp) begin
            if (exp_fp_q.size() == 0) chk("fp_unexpected_hs", {5'd0, code_fp}, 8'hFF);
            else chk("fp_sb_code", {5'd0, code_fp}, {5'd0, exp_fp_q.pop_front()});
        end
        if (!rst && valid_rr && ready_rr) begin
            if (exp_rr_q.size() == 0) chk("rr_unexpected_hs", {5'd0, code_rr}, 8'hFF);
            else chk("rr_sb_code", {5'd0, code_rr}, {5'd0, exp_rr_q.pop_front()});
        end
    end

    initial begin
        rst = 1'b1; req_fp = 8'h04; req_rr = 8'h00; ready_fp = 1'b1; ready_rr = 1'b1;
        tick(); tick();
        chk("rst_valid", {7'd0, valid_fp}, 8'h00);
        chk("rst_code", {5'd0, code_fp}, 8'h00);
        chk("rst_pending", pending_fp, 8'h00);
        chk("rst_ovf", {7'd0, ovf_fp}, 8'h00);

        // Line held high across reset release: never an event.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held_valid", {7'd0, valid_fp}, 8'h00);
            chk("held_pending", pending_fp, 8'h00);
        end

        // Single pulse on req[5]: valid two cycles later.
        req_fp = 8'h24; exp_fp_q.push_back(3'd5);
        tick();                                   // cycle N+1
        chk("p5_pending", pending_fp, 8'h20);
        chk("p5_valid_n1", {7'd0, valid_fp}, 8'h00);
        req_fp = 8'h04;
        tick();                                   // cycle N+2
        chk("p5_valid", {7'd0, valid_fp}, 8'h01);
        chk("p5_code", {5'd0, code_fp}, 8'h05);
        tick();                                   // after handshake
        chk("p5_after_valid", {7'd0, valid_fp}, 8'h00);
        chk("p5_after_pending", pending_fp, 8'h00);

        // Three simultaneous edges, fixed priority, one per 2 cycles.
        req_fp = 8'h00;
        tick();
        req_fp = 8'h91;
        exp_fp_q.push_back(3'd0); exp_fp_q.push_back(3'd4); exp_fp_q.push_back(3'd7);
        tick();
        chk("m_pending", pending_fp, 8'h91);
        tick();
        chk("m_v0", {7'd0, valid_fp}, 8'h01);
        chk("m_c0", {5'd0, code_fp}, 8'h00);
        tick();
        chk("m_bubble0", {7'd0, valid_fp}, 8'h00);
        tick();
        chk("m_c4", {5'd0, code_fp}, 8'h04);
        tick();
        chk("m_bubble1", {7'd0, valid_fp}, 8'h00);
        tick();
        chk("m_c7", {5'd0, code_fp}, 8'h07);
        tick();
        chk("m_end_valid", {7'd0, valid_fp}, 8'h00);
        chk("m_ovf", {7'd0, ovf_fp}, 8'h00);

        // Stall: code 3 held 5 cycles, req[1] rises, req[3] re-rises -> ovf.
        ready_fp = 1'b0; req_fp = 8'h08;
        tick(); tick();                           // cycle A
        req_fp = 8'h0A;
        for (int i = 0; i < 5; i++) begin
            chk("st_valid", {7'd0, valid_fp}, 8'h01);
            chk("st_code", {5'd0, code_fp}, 8'h03);
            if (i == 0) req_fp = 8'h0A;
            if (i == 1) req_fp = 8'h02;
            if (i == 2) req_fp = 8'h0A;
            tick();
        end
        chk("st_ovf", {7'd0, ovf_fp}, 8'h01);
        chk("st_pending", pending_fp, 8'h0A);
        // cycle A+5: release
        chk("st_code_last", {5'd0, code_fp}, 8'h03);
        ready_fp = 1'b1; exp_fp_q.push_back(3'd3); exp_fp_q.push_back(3'd1);
        tick();
        chk("st_bubble", {7'd0, valid_fp}, 8'h00);
        tick();
        chk("st_next_code", {5'd0, code_fp}, 8'h01);
        tick();
        chk("st_done_pending", pending_fp, 8'h00);
        chk("st_ovf_sticky", {7'd0, ovf_fp}, 8'h01);

        // Reset while offering drops the offer.
        ready_fp = 1'b0; req_fp = 8'h4A;
        tick(); tick();
        chk("ro_valid_before", {7'd0, valid_fp}, 8'h01);
        chk("ro_code_before", {5'd0, code_fp}, 8'h06);
        rst = 1'b1; req_fp = 8'h00;
        tick();
        chk("ro_valid", {7'd0, valid_fp}, 8'h00);
        chk("ro_pending", pending_fp, 8'h00);
        chk("ro_ovf_cleared", {7'd0, ovf_fp}, 8'h00);
        rst = 1'b0; ready_fp = 1'b1;
        tick();
        chk("ro_stays_idle", {7'd0, valid_fp}, 8'h00);

        // Edge on req[2] in the very cycle code 2 is acknowledged.
        req_fp = 8'h04; exp_fp_q.push_back(3'd2); exp_fp_q.push_back(3'd2);
        tick();
        req_fp = 8'h00;
        tick();
        chk("sa_code", {5'd0, code_fp}, 8'h02);
        chk("sa_valid", {7'd0, valid_fp}, 8'h01);
        req_fp = 8'h04;
        tick();
        chk("sa_repending", pending_fp, 8'h04);
        chk("sa_ovf", {7'd0, ovf_fp}, 8'h00);
        chk("sa_bubble", {7'd0, valid_fp}, 8'h00);
        tick();
        chk("sa_again_valid", {7'd0, valid_fp}, 8'h01);
        chk("sa_again_code", {5'd0, code_fp}, 8'h02);
        tick();
        chk("sa_end_pending", pending_fp, 8'h00);
        chk("sa_end_ovf", {7'd0, ovf_fp}, 8'h00);

        // Round robin: 1 then 6, then 7 before 2 since ptr=7.
        req_rr = 8'h42; exp_rr_q.push_back(3'd1); exp_rr_q.push_back(3'd6);
        tick(); tick();
        chk("rr_c1", {5'd0, code_rr}, 8'h01);
        tick(); tick();
        chk("rr_c6", {5'd0, code_rr}, 8'h06);
        tick();
        req_rr = 8'h84; exp_rr_q.push_back(3'd7); exp_rr_q.push_back(3'd2);
        tick();
        chk("rr_pending", pending_rr, 8'h84);
        tick();
        chk("rr_c7", {5'd0, code_rr}, 8'h07);
        tick(); tick();
        chk("rr_c2", {5'd0, code_rr}, 8'h02);
        tick();
        chk("rr_end_pending", pending_rr, 8'h00);
        chk("rr_ovf", {7'd0, ovf_rr}, 8'h00);

        tick(); tick();
        chk("fp_sb_drained", 8'(exp_fp_q.size()), 8'h00);
        chk("rr_sb_drained", 8'(exp_rr_q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/event_encoder.md
Name: event_encoder

Overview:
- Sequential 8-to-3 encoder: the other direction of the lab's 3-to-8 one-hot decoder.
- Watches 8 request lines (buttons or strobes) and captures each rising edge as a pending event.
- Emits one 3-bit index per event over a valid/ready handshake, so a downstream consumer (e.g. the decoder driving LEDs, or a display) can service each event individually.
- Arbitration between simultaneous events is fixed-priority or round-robin, selected by parameter.

Parameters:
- ROUND_ROBIN, 0, 0 = lowest index wins; 1 = search starts at the index after the last accepted one.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- req  input  8  request lines, level; only a 0->1 transition creates an event
- code  output  3  index of the offered event; valid only while valid=1
- valid  output  1  an event is being offered
- ready  input  1  consumer accepts; handshake occurs on a cycle with valid=1 and ready=1
- pending  output  8  registered pending-event mask (debug)
- ovf  output  1  sticky: an event was lost

Behaviour:
- Reset (rst=1 at clk edge):
  - pending=0, code=0, valid=0, ovf=0, ptr=0, FSM=IDLE.
  - req_q loads req, so lines already high at reset release do not generate events.
- Edge detect: req_q <= req every cycle. edge = req & ~req_q, computed from the current req and the registered req_q.
- Pending update each cycle: pending <= (pending & ~ack_mask) | edge.
  - ack_mask is one-hot of code when a handshake occurs, else 0.
- Overflow: ovf <= 1 if any bit k has edge[k]=1, pending[k]=1, and k is not being acknowledged this cycle. ovf is cleared only by rst.
- Simultaneous edge and acknowledge on the same bit: the bit stays set (new event) and ovf is not set.
- FSM, two states, registered outputs:
  - IDLE: valid=0. If pending != 0, load code with the selected index, go to OFFER. Edges arriving in this same cycle are not visible to selection (pending is registered).
  - OFFER: valid=1; code is held stable until the handshake. On ready=1: clear that pending bit, set ptr <= code+1 (mod 8) when ROUND_ROBIN=1, go to IDLE.
- Throughput: at most one event per 2 cycles (mandatory IDLE bubble).
- Latency: req rises in cycle N with rst=0 -> edge visible at the end of N -> pending set at edge N -> code loaded at edge N+1 -> valid=1 during cycle N+2.
- Selection: first set bit of pending, scanning upward from base with wrap 7->0.
  - base = 0 when ROUND_ROBIN=0; base = ptr when ROUND_ROBIN=1.
  - ptr is unused (held 0) when ROUND_ROBIN=0.
- A bit whose event is offered stays in pending until acknowledged. A new edge on it meanwhile sets ovf (bit already pending).
- Falling edges and held-high levels produce nothing.
- rst mid-OFFER: the offer is dropped immediately. Valid=0 in the cycle after the reset edge, and all pending events are discarded.
- ready while valid=0 is ignored.

Test Plan:
- Reset with req=8'h04 held high, release -> no event ever; valid stays 0 and pending stays 8'h00.
- req[5] pulses 0->1 in cycle N, ready=1 -> valid=1 with code=3'd5 in cycle N+2; after the handshake pending=0 and valid=0 the next cycle.
- req 8'h00->8'h91 in one cycle, ready=1, ROUND_ROBIN=0 -> codes 0, 4, 7 in order, one every 2 cycles; ovf=0.
- ROUND_ROBIN=1: events on bits 1 and 6 are served, then new simultaneous edges on bits 2 and 7 -> code 7 served before 2 (ptr=7 after accepting 6).
- Offer code=3 with ready=0 held for 5 cycles while req[1] rises -> code stays 3; after ready, next offer is 1. A second rise on req[3] during the stall sets ovf=1, which persists until rst.
- Edge on req[2] in the same cycle as the handshake of code=2 -> pending[2] re-set, ovf=0, code 2 offered again 2 cycles later.
